// File: rtl/instr_fetch_decode.sv
//==============================================================================
// Module      : instr_fetch_decode
// Description : CPU front end. Owns the PC, reads the synchronous instruction
//               memory, decodes opcode/dst/srcA/srcB, and resolves jmp and halt
//               locally. All other ops go to the datapath over a valid/ready
//               handshake. Conditional jumps then wait for the branch verdict.
//               Optional single-step gating when IFD_STEP_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch_decode #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_PC    = 8'h00,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                   Clk,
   input  logic                   Resetn,
   input  logic                   Start,
`ifdef IFD_STEP_EN
   input  logic                   Step,
`endif
   output logic                   imRdEn,
   output logic [ADDR_WIDTH-1:0]  imAddr,
   input  logic [INSTR_WIDTH-1:0] imData,
   output logic                   opValid,
   input  logic                   opReady,
   output logic [7:0]             opCode,
   output logic [7:0]             opDst,
   output logic [7:0]             opSrcA,
   output logic [7:0]             opSrcB,
   input  logic                   brValid,
   input  logic                   brTaken,
   output logic [ADDR_WIDTH-1:0]  pcOut,
   output logic                   Halted,
   output logic                   Illegal,
   output logic [CNT_WIDTH-1:0]   retireCnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_BRWAIT = 3'd4,
      S_HALT   = 3'd5
`ifdef IFD_STEP_EN
      ,S_STEP  = 3'd6
`endif
   } state_t;

   // State entered after an instruction retires and the next fetch is due.
`ifdef IFD_STEP_EN
   localparam state_t S_NEXT = S_STEP;
`else
   localparam state_t S_NEXT = S_FETCH;
`endif

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic [ADDR_WIDTH-1:0]   pc_inc_d;
   logic [ADDR_WIDTH-1:0]   jmp_tgt_d;
   logic [ADDR_WIDTH-1:0]   br_tgt_d;
   logic [INSTR_WIDTH-1:0]  ir_q;
   logic                    illegal_q;
   logic [CNT_WIDTH-1:0]    retire_q;
   logic [CNT_WIDTH-1:0]    retire_d;

   logic [7:0]              dec_op;
   logic                    dec_jmp;
   logic                    dec_halt;
   logic                    dec_issue;
   logic                    ir_is_br;

   // PC increment wraps naturally at all-ones; the counter does likewise.
   assign pc_inc_d  = pc_q + ADDR_WIDTH'(1);
   assign retire_d  = retire_q + CNT_WIDTH'(1);
   assign jmp_tgt_d = ADDR_WIDTH'(imData[23:16]);
   assign br_tgt_d  = ADDR_WIDTH'(ir_q[23:16]);

   // Decode classes of the word arriving from memory this cycle.
   assign dec_op    = imData[31:24];
   assign dec_jmp   = (dec_op == 8'h08);
   assign dec_halt  = (dec_op == 8'h0f);
   assign dec_issue = (dec_op <= 8'h0d) && !dec_jmp;
   assign ir_is_br  = (ir_q[31:24] == 8'h09) || (ir_q[31:24] == 8'h0a) ||
                      (ir_q[31:24] == 8'h0b);

   // Sequencer: PC, instruction register, illegal flag and retire counter.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         pc_q      <= START_PC;
         ir_q      <= '0;
         illegal_q <= 1'b0;
         retire_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  pc_q     <= START_PC;
                  retire_q <= '0;
                  state_q  <= S_FETCH;
               end
            end
            S_FETCH: begin
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               if (dec_jmp) begin
                  pc_q     <= jmp_tgt_d;
                  retire_q <= retire_d;
                  state_q  <= S_NEXT;
               end else if (dec_halt) begin
                  retire_q <= retire_d;
                  state_q  <= S_HALT;
               end else if (dec_issue) begin
                  ir_q    <= imData;
                  state_q <= S_ISSUE;
               end else begin
                  // 0e and anything above 0f: stop without retiring.
                  illegal_q <= 1'b1;
                  state_q   <= S_HALT;
               end
            end
            S_ISSUE: begin
               if (opReady) begin
                  if (ir_is_br) begin
                     // Verdict arrives later; brValid this cycle is not looked at.
                     state_q <= S_BRWAIT;
                  end else begin
                     pc_q     <= pc_inc_d;
                     retire_q <= retire_d;
                     state_q  <= S_NEXT;
                  end
               end
            end
            S_BRWAIT: begin
               if (brValid) begin
                  pc_q     <= brTaken ? br_tgt_d : pc_inc_d;
                  retire_q <= retire_d;
                  state_q  <= S_NEXT;
               end
            end
            S_HALT: begin
               if (Start) begin
                  pc_q      <= START_PC;
                  illegal_q <= 1'b0;
                  retire_q  <= '0;
                  state_q   <= S_FETCH;
               end
            end
`ifdef IFD_STEP_EN
            S_STEP: begin
               if (Step) begin
                  state_q <= S_FETCH;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign imRdEn    = (state_q == S_FETCH);
   assign imAddr    = imRdEn ? pc_q : '0;
   assign opValid   = (state_q == S_ISSUE);
   assign opCode    = ir_q[31:24];
   assign opDst     = ir_q[23:16];
   assign opSrcA    = ir_q[15:8];
   assign opSrcB    = ir_q[7:0];
   assign pcOut     = pc_q;
   assign Halted    = (state_q == S_HALT);
   assign Illegal   = illegal_q;
   assign retireCnt = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
//==============================================================================
// Module      : tb_instr_fetch_decode
// Description : Directed self-checking bench for instr_fetch_decode with a
//               1-cycle synchronous instruction memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch_decode;

   logic        Clk = 1'b0;
   logic        Resetn;
   logic        Start;
   logic        imRdEn;
   logic [7:0]  imAddr;
   logic [31:0] imData;
   logic        opValid;
   logic        opReady;
   logic [7:0]  opCode, opDst, opSrcA, opSrcB;
   logic        brValid, brTaken;
   logic [7:0]  pcOut;
   logic        Halted, Illegal;
   logic [15:0] retireCnt;
`ifdef IFD_STEP_EN
   logic        step_in = 1'b1;
`endif

   logic [31:0] mem [0:255];
   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   // Synchronous memory: address registered, data one cycle later.
   always @(posedge Clk) begin
      if (imRdEn) imData <= mem[imAddr];
   end

   instr_fetch_decode dut (
      .Clk(Clk), .Resetn(Resetn), .Start(Start),
`ifdef IFD_STEP_EN
      .Step(step_in),
`endif
      .imRdEn(imRdEn), .imAddr(imAddr), .imData(imData),
      .opValid(opValid), .opReady(opReady),
      .opCode(opCode), .opDst(opDst), .opSrcA(opSrcA), .opSrcB(opSrcB),
      .brValid(brValid), .brTaken(brTaken), .pcOut(pcOut),
      .Halted(Halted), .Illegal(Illegal), .retireCnt(retireCnt)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (imRdEn !== 1'b0) begin bad++; $display("FAIL rst_imRdEn: got %b want 0", imRdEn); end
      total++; if (imAddr !== 8'h00) begin bad++; $display("FAIL rst_imAddr: got %h want 00", imAddr); end
      total++; if (opValid !== 1'b0) begin bad++; $display("FAIL rst_opValid: got %b want 0", opValid); end
      total++; if ({opCode, opDst, opSrcA, opSrcB} !== 32'h0) begin bad++; $display("FAIL rst_fields: got %h want 0", {opCode, opDst, opSrcA, opSrcB}); end
      total++; if (pcOut !== 8'h00) begin bad++; $display("FAIL rst_pc: got %h want 00", pcOut); end
      total++; if ({Halted, Illegal} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {Halted, Illegal}); end
      total++; if (retireCnt !== 16'd0) begin bad++; $display("FAIL rst_retire: got %0d want 0", retireCnt); end
      tick();
      Resetn = 1'b1;
      tick();
      total++; if (imRdEn !== 1'b0) begin bad++; $display("FAIL idle_no_fetch: got %b want 0", imRdEn); end
   endtask

   // Word 0c_00_09_00 at 00: issue on cycle 2 after fetch, next fetch at 01.
   task automatic test_arith();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h00}) begin bad++; $display("FAIL arith_fetch: got %b/%h want 1/00", imRdEn, imAddr); end
      tick();
      total++; if (opValid !== 1'b0) begin bad++; $display("FAIL arith_decode_valid: got %b want 0", opValid); end
      tick();
      total++; if (opValid !== 1'b1) begin bad++; $display("FAIL arith_issue_valid: got %b want 1", opValid); end
      total++; if ({opCode, opDst, opSrcA, opSrcB} !== 32'h0c000900) begin bad++; $display("FAIL arith_fields: got %h want 0c000900", {opCode, opDst, opSrcA, opSrcB}); end
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h01}) begin bad++; $display("FAIL arith_next_fetch: got %b/%h want 1/01", imRdEn, imAddr); end
      total++; if (retireCnt !== 16'd1) begin bad++; $display("FAIL arith_retire: got %0d want 1", retireCnt); end
   endtask

   // jmp at 01 -> 06, jmp at 06 -> 10; two cycles each, no opValid.
   task automatic test_jmp();
      tick();
      total++; if (opValid !== 1'b0) begin bad++; $display("FAIL jmp1_valid: got %b want 0", opValid); end
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h06}) begin bad++; $display("FAIL jmp1_target: got %b/%h want 1/06", imRdEn, imAddr); end
      tick();
      total++; if (opValid !== 1'b0) begin bad++; $display("FAIL jmp2_valid: got %b want 0", opValid); end
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h10}) begin bad++; $display("FAIL jmp2_target: got %b/%h want 1/10", imRdEn, imAddr); end
      total++; if (retireCnt !== 16'd3) begin bad++; $display("FAIL jmp_retire: got %0d want 3", retireCnt); end
   endtask

   // Op 01_02_03_04 at 10 held with opReady low for 5 cycles.
   task automatic test_stall();
      opReady = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         total++; if (opValid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, opValid); end
         total++; if ({opCode, opDst, opSrcA, opSrcB} !== 32'h01020304) begin bad++; $display("FAIL stall_fields[%0d]: got %h want 01020304", i, {opCode, opDst, opSrcA, opSrcB}); end
         total++; if (retireCnt !== 16'd3) begin bad++; $display("FAIL stall_retire[%0d]: got %0d want 3", i, retireCnt); end
         tick();
      end
      total++; if (opValid !== 1'b1) begin bad++; $display("FAIL stall_before_accept: got %b want 1", opValid); end
      opReady = 1'b1;
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h11}) begin bad++; $display("FAIL stall_next_fetch: got %b/%h want 1/11", imRdEn, imAddr); end
      total++; if (retireCnt !== 16'd4) begin bad++; $display("FAIL stall_retire_once: got %0d want 4", retireCnt); end
   endtask

   // Branch 0b_14 at 11: taken -> 14, jmp back to 11, not taken -> 12, halt.
   task automatic test_branch();
      brValid = 1'b1;              // present early: must be ignored before BRWAIT
      brTaken = 1'b1;
      tick();
      tick();
      total++; if ({opValid, opCode} !== {1'b1, 8'h0b}) begin bad++; $display("FAIL br_issue: got %b/%h want 1/0b", opValid, opCode); end
      tick();
      brValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if ({imRdEn, opValid} !== 2'b00) begin bad++; $display("FAIL br_wait[%0d]: got %b want 00", i, {imRdEn, opValid}); end
         total++; if (retireCnt !== 16'd4) begin bad++; $display("FAIL br_wait_retire[%0d]: got %0d want 4", i, retireCnt); end
         tick();
      end
      brValid = 1'b1;
      brTaken = 1'b1;
      tick();
      brValid = 1'b0;
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h14}) begin bad++; $display("FAIL br_taken_fetch: got %b/%h want 1/14", imRdEn, imAddr); end
      total++; if (retireCnt !== 16'd5) begin bad++; $display("FAIL br_taken_retire: got %0d want 5", retireCnt); end
      tick();
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h11}) begin bad++; $display("FAIL br_loop_fetch: got %b/%h want 1/11", imRdEn, imAddr); end
      tick();
      tick();
      tick();
      brValid = 1'b1;
      brTaken = 1'b0;
      tick();
      brValid = 1'b0;
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h12}) begin bad++; $display("FAIL br_not_taken_fetch: got %b/%h want 1/12", imRdEn, imAddr); end
      total++; if (retireCnt !== 16'd7) begin bad++; $display("FAIL br_not_taken_retire: got %0d want 7", retireCnt); end
   endtask

   // Halt at 12, then restart; word at 01 replaced by illegal 0e.
   task automatic test_halt_illegal();
      tick();
      tick();
      total++; if ({Halted, Illegal} !== 2'b10) begin bad++; $display("FAIL halt_flags: got %b want 10", {Halted, Illegal}); end
      total++; if (retireCnt !== 16'd8) begin bad++; $display("FAIL halt_retire: got %0d want 8", retireCnt); end
      total++; if (pcOut !== 8'h12) begin bad++; $display("FAIL halt_pc: got %h want 12", pcOut); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({imRdEn, Halted} !== 2'b01) begin bad++; $display("FAIL halt_hold[%0d]: got %b want 01", i, {imRdEn, Halted}); end
      end
      mem[8'h01] = 32'h0e00_0000;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      total++; if ({imRdEn, imAddr, Halted} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL restart_fetch: got %b/%h/%b want 1/00/0", imRdEn, imAddr, Halted); end
      total++; if (retireCnt !== 16'd0) begin bad++; $display("FAIL restart_retire: got %0d want 0", retireCnt); end
      tick();
      tick();
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'h01}) begin bad++; $display("FAIL restart_second_fetch: got %b/%h want 1/01", imRdEn, imAddr); end
      tick();
      tick();
      total++; if ({Halted, Illegal} !== 2'b11) begin bad++; $display("FAIL illegal_flags: got %b want 11", {Halted, Illegal}); end
      total++; if (retireCnt !== 16'd1) begin bad++; $display("FAIL illegal_no_retire: got %0d want 1", retireCnt); end
   endtask

   // jmp 00 -> ff, op at ff, PC wraps to 00.
   task automatic test_wrap();
      mem[8'h00] = 32'h08ff_0000;
      mem[8'hff] = 32'h0301_0203;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      total++; if ({Halted, Illegal} !== 2'b00) begin bad++; $display("FAIL restart_clears: got %b want 00", {Halted, Illegal}); end
      tick();
      tick();
      total++; if ({imRdEn, imAddr} !== {1'b1, 8'hff}) begin bad++; $display("FAIL wrap_fetch_ff: got %b/%h want 1/ff", imRdEn, imAddr); end
      tick();
      tick();
      tick();
      total++; if ({imRdEn, imAddr, pcOut} !== {1'b1, 8'h00, 8'h00}) begin bad++; $display("FAIL wrap_fetch_00: got %b/%h/%h want 1/00/00", imRdEn, imAddr, pcOut); end
      total++; if (retireCnt !== 16'd2) begin bad++; $display("FAIL wrap_retire: got %0d want 2", retireCnt); end
   endtask

   // Asynchronous reset while opValid is high.
   task automatic test_reset_mid();
      opReady = 1'b0;
      tick();
      tick();
      tick();
      tick();
      total++; if ({opValid, opCode} !== {1'b1, 8'h03}) begin bad++; $display("FAIL midrst_pre_valid: got %b/%h want 1/03", opValid, opCode); end
      #2;
      Resetn = 1'b0;
      #1;
      total++; if (opValid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", opValid); end
      total++; if ({pcOut, retireCnt} !== 24'h0) begin bad++; $display("FAIL midrst_state: got %h/%0d want 00/0", pcOut, retireCnt); end
      total++; if ({opCode, opDst, opSrcA, opSrcB} !== 32'h0) begin bad++; $display("FAIL midrst_fields: got %h want 0", {opCode, opDst, opSrcA, opSrcB}); end
      #3;
      Resetn = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
      mem[8'h00] = 32'h0c00_0900;
      mem[8'h01] = 32'h0806_0000;
      mem[8'h06] = 32'h0810_0000;
      mem[8'h10] = 32'h0102_0304;
      mem[8'h11] = 32'h0b14_0000;
      mem[8'h14] = 32'h0811_aa55;
      mem[8'h12] = 32'h0f00_0000;
      Resetn  = 1'b0;
      Start   = 1'b0;
      opReady = 1'b1;
      brValid = 1'b0;
      brTaken = 1'b0;
      test_reset();
      test_arith();
      test_jmp();
      test_stall();
      test_branch();
      test_halt_illegal();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
